// File: rtl/fifo_cmd_arbiter_pkg.sv
// fifo_cmd_arbiter_pkg
//   Shared constants and types for the fifo command port: command type
//   encodings, field widths, the route-queue entry and the arbiter FSM
//   state type. Also intended for reuse by the AXI4 cache bridge.
package fifo_cmd_arbiter_pkg;

  localparam int unsigned ADDR_W  = 27;
  localparam int unsigned DATA_W  = 128;
  localparam int unsigned MASK_W  = 16;
  localparam int unsigned BURST_W = 6;

  localparam logic CMD_WT = 1'b0;
  localparam logic CMD_RD = 1'b1;

  // One outstanding read: which requester issued it and its beat count - 1.
  typedef struct packed {
    logic               id;
    logic [BURST_W-1:0] beats;
  } route_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_cmd_arbiter_if.sv
// fifo_cmd_arbiter_if
//   Bundles both requester command/response channels, the downstream fifo
//   command/response channel and the orphan flag.
//   slave  : arbiter side (takes requester commands, drives downstream).
//   master : environment side (requesters plus downstream memory).
interface fifo_cmd_arbiter_if;
  import fifo_cmd_arbiter_pkg::*;

  logic               m0_cmd_valid;
  logic               m0_cmd_ready;
  logic               m0_cmd_type;
  logic [ADDR_W-1:0]  m0_cmd_addr;
  logic [BURST_W-1:0] m0_cmd_burst_cnt;
  logic [DATA_W-1:0]  m0_cmd_wt_data;
  logic [MASK_W-1:0]  m0_cmd_wt_mask;
  logic               m0_rsp_valid;
  logic               m0_rsp_ready;
  logic [DATA_W-1:0]  m0_rsp_data;

  logic               m1_cmd_valid;
  logic               m1_cmd_ready;
  logic               m1_cmd_type;
  logic [ADDR_W-1:0]  m1_cmd_addr;
  logic [BURST_W-1:0] m1_cmd_burst_cnt;
  logic [DATA_W-1:0]  m1_cmd_wt_data;
  logic [MASK_W-1:0]  m1_cmd_wt_mask;
  logic               m1_rsp_valid;
  logic               m1_rsp_ready;
  logic [DATA_W-1:0]  m1_rsp_data;

  logic               io_fifo_cmd_valid;
  logic               io_fifo_cmd_ready;
  logic               io_fifo_cmd_type;
  logic [ADDR_W-1:0]  io_fifo_cmd_addr;
  logic [BURST_W-1:0] io_fifo_cmd_burst_cnt;
  logic [DATA_W-1:0]  io_fifo_cmd_wt_data;
  logic [MASK_W-1:0]  io_fifo_cmd_wt_mask;
  logic               io_fifo_rsp_valid;
  logic               io_fifo_rsp_ready;
  logic [DATA_W-1:0]  io_fifo_rsp_data;

  logic               rsp_orphan;

  modport slave (
    input  m0_cmd_valid, m0_cmd_type, m0_cmd_addr, m0_cmd_burst_cnt,
           m0_cmd_wt_data, m0_cmd_wt_mask, m0_rsp_ready,
    output m0_cmd_ready, m0_rsp_valid, m0_rsp_data,
    input  m1_cmd_valid, m1_cmd_type, m1_cmd_addr, m1_cmd_burst_cnt,
           m1_cmd_wt_data, m1_cmd_wt_mask, m1_rsp_ready,
    output m1_cmd_ready, m1_rsp_valid, m1_rsp_data,
    output io_fifo_cmd_valid, io_fifo_cmd_type, io_fifo_cmd_addr,
           io_fifo_cmd_burst_cnt, io_fifo_cmd_wt_data, io_fifo_cmd_wt_mask,
    input  io_fifo_cmd_ready, io_fifo_rsp_valid, io_fifo_rsp_data,
    output io_fifo_rsp_ready, rsp_orphan
  );

  modport master (
    output m0_cmd_valid, m0_cmd_type, m0_cmd_addr, m0_cmd_burst_cnt,
           m0_cmd_wt_data, m0_cmd_wt_mask, m0_rsp_ready,
    input  m0_cmd_ready, m0_rsp_valid, m0_rsp_data,
    output m1_cmd_valid, m1_cmd_type, m1_cmd_addr, m1_cmd_burst_cnt,
           m1_cmd_wt_data, m1_cmd_wt_mask, m1_rsp_ready,
    input  m1_cmd_ready, m1_rsp_valid, m1_rsp_data,
    input  io_fifo_cmd_valid, io_fifo_cmd_type, io_fifo_cmd_addr,
           io_fifo_cmd_burst_cnt, io_fifo_cmd_wt_data, io_fifo_cmd_wt_mask,
    output io_fifo_cmd_ready, io_fifo_rsp_valid, io_fifo_rsp_data,
    input  io_fifo_rsp_ready, rsp_orphan
  );

endinterface

// File: rtl/fifo_cmd_arbiter_route_fifo.sv
// route_fifo
//   Synchronous FIFO of route entries. Pointers carry one extra wrap bit
//   so full and empty are distinguished without a counter.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write an entry (ignored while full)
//   pop      : drop the head entry (ignored while empty)
//   head     : current head entry
//   full/empty
module route_fifo
  import fifo_cmd_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  route_entry_t din,
  input  logic         pop,
  output route_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  route_entry_t mem_q [DEPTH];
  route_entry_t mem_d [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/fifo_cmd_arbiter.sv
// fifo_cmd_arbiter
//   Shares one DDR fifo command channel between two requesters. Commands are
//   granted round-robin in IDLE and held in HOLD until the downstream accepts.
//   Reads record {requester, beats} in a route queue so the in-order read
//   responses are steered back to the issuing requester with no added latency.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : requester 0/1 channels, downstream fifo channel, rsp_orphan
module fifo_cmd_arbiter
  import fifo_cmd_arbiter_pkg::*;
#(
  parameter int unsigned ROUTE_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  fifo_cmd_arbiter_if.slave bus
);

  arb_state_e         state_q, state_d;
  logic               gnt_q, gnt_d;
  logic               rr_q, rr_d;
  logic [BURST_W-1:0] bcnt_q, bcnt_d;
  logic               orphan_q, orphan_d;

  logic               q_push;
  logic               q_pop;
  logic               q_full;
  logic               q_empty;
  route_entry_t       q_head;
  route_entry_t       q_din;

  logic               elig0;
  logic               elig1;
  logic               sel_valid;
  logic               sel_type;
  logic [ADDR_W-1:0]  sel_addr;
  logic [BURST_W-1:0] sel_burst;
  logic [DATA_W-1:0]  sel_data;
  logic [MASK_W-1:0]  sel_mask;
  logic               head_ready;

  // A read is only eligible while the route queue has room for its entry.
  assign elig0 = bus.m0_cmd_valid && (bus.m0_cmd_type == CMD_WT || !q_full);
  assign elig1 = bus.m1_cmd_valid && (bus.m1_cmd_type == CMD_WT || !q_full);

  assign sel_valid = gnt_q ? bus.m1_cmd_valid     : bus.m0_cmd_valid;
  assign sel_type  = gnt_q ? bus.m1_cmd_type      : bus.m0_cmd_type;
  assign sel_addr  = gnt_q ? bus.m1_cmd_addr      : bus.m0_cmd_addr;
  assign sel_burst = gnt_q ? bus.m1_cmd_burst_cnt : bus.m0_cmd_burst_cnt;
  assign sel_data  = gnt_q ? bus.m1_cmd_wt_data   : bus.m0_cmd_wt_data;
  assign sel_mask  = gnt_q ? bus.m1_cmd_wt_mask   : bus.m0_cmd_wt_mask;

  assign q_din = '{id: gnt_q, beats: sel_burst};

  route_fifo #(
    .DEPTH (ROUTE_DEPTH)
  ) u_route_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .din   (q_din),
    .pop   (q_pop),
    .head  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  // Arbitration FSM: next state and command-side outputs.
  always_comb begin
    state_d                   = state_q;
    gnt_d                     = gnt_q;
    rr_d                      = rr_q;
    q_push                    = 1'b0;
    bus.io_fifo_cmd_valid     = 1'b0;
    bus.io_fifo_cmd_type      = 1'b0;
    bus.io_fifo_cmd_addr      = '0;
    bus.io_fifo_cmd_burst_cnt = '0;
    bus.io_fifo_cmd_wt_data   = '0;
    bus.io_fifo_cmd_wt_mask   = '0;
    bus.m0_cmd_ready          = 1'b0;
    bus.m1_cmd_ready          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (elig0 && elig1) begin
          gnt_d   = rr_q;
          state_d = ST_HOLD;
        end else if (elig0) begin
          gnt_d   = 1'b0;
          state_d = ST_HOLD;
        end else if (elig1) begin
          gnt_d   = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        bus.io_fifo_cmd_valid     = sel_valid;
        bus.io_fifo_cmd_type      = sel_type;
        bus.io_fifo_cmd_addr      = sel_addr;
        bus.io_fifo_cmd_burst_cnt = sel_burst;
        bus.io_fifo_cmd_wt_data   = sel_data;
        bus.io_fifo_cmd_wt_mask   = sel_mask;
        if (gnt_q) bus.m1_cmd_ready = bus.io_fifo_cmd_ready;
        else       bus.m0_cmd_ready = bus.io_fifo_cmd_ready;
        if (sel_valid && bus.io_fifo_cmd_ready) begin
          rr_d    = ~gnt_q;
          q_push  = (sel_type == CMD_RD);
          state_d = ST_IDLE;
        end else if (!sel_valid) begin
          // Requester withdrew its command: abandon the grant, nothing queued.
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.m0_rsp_data = bus.io_fifo_rsp_data;
  assign bus.m1_rsp_data = bus.io_fifo_rsp_data;
  assign bus.rsp_orphan  = orphan_q;

  // Response routing: steer beats to the head requester, pop after its last beat.
  always_comb begin
    bcnt_d                = bcnt_q;
    orphan_d              = orphan_q;
    q_pop                 = 1'b0;
    head_ready            = 1'b1;
    bus.m0_rsp_valid      = 1'b0;
    bus.m1_rsp_valid      = 1'b0;
    if (q_empty) begin
      // Nobody is waiting: sink the beat and remember it happened.
      if (bus.io_fifo_rsp_valid) orphan_d = 1'b1;
    end else begin
      if (q_head.id) begin
        bus.m1_rsp_valid = bus.io_fifo_rsp_valid;
        head_ready       = bus.m1_rsp_ready;
      end else begin
        bus.m0_rsp_valid = bus.io_fifo_rsp_valid;
        head_ready       = bus.m0_rsp_ready;
      end
      if (bus.io_fifo_rsp_valid && head_ready) begin
        if (bcnt_q == q_head.beats) begin
          q_pop  = 1'b1;
          bcnt_d = '0;
        end else begin
          bcnt_d = bcnt_q + {{(BURST_W-1){1'b0}}, 1'b1};
        end
      end
    end
    bus.io_fifo_rsp_ready = head_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 1'b0;
      rr_q     <= 1'b0;
      bcnt_q   <= '0;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_q     <= rr_d;
      bcnt_q   <= bcnt_d;
      orphan_q <= orphan_d;
    end
  end

endmodule
